// File: rtl/i2c_codec_writer.sv
// i2c_codec_writer: serialises one 24-bit codec word onto I2C.
// Ticks at a quarter-bit rate; END reports idle/complete.
module i2c_codec_writer #(
  parameter int CLK_DIV = 128
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [23:0] DATA,
  input  logic        GO,
  output logic        I2C_SCLK,
  output logic        SDA_OE,
  input  logic        SDA_IN,
  output logic        END,
  output logic        ACK_ERR
);

  typedef enum logic [2:0] {
    IDLE, START, BIT, STOP, DONE
  } state_t;

  localparam logic [9:0] DIV_MAX = 10'(CLK_DIV - 1);

  state_t      state, state_n;
  logic [1:0]  step, step_n;
  logic [4:0]  slot, slot_n;
  logic [9:0]  div, div_n;
  logic [23:0] sh, sh_n;
  logic        scl, scl_n;
  logic        oe, oe_n;
  logic        end_q, end_n;
  logic        err, err_n;
  logic [2:0]  go_s;
  logic [1:0]  sda_s;
  logic        go_rise;
  logic        tick;
  logic        ack_now;
  logic        ack_next;

  assign go_rise  = go_s[1] & ~go_s[2];
  assign tick     = (div == DIV_MAX);
  assign ack_now  = (slot == 5'd8) || (slot == 5'd17)
                 || (slot == 5'd26);
  assign ack_next = (slot == 5'd7) || (slot == 5'd16)
                 || (slot == 5'd25);

  assign I2C_SCLK = scl;
  assign SDA_OE   = oe;
  assign END      = end_q;
  assign ACK_ERR  = err;

  // GO and SDA synchronisers; go_s[2] is the edge-detect history
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      go_s  <= 3'b000;
      sda_s <= 2'b11;
    end else begin
      go_s  <= {go_s[1:0], GO};
      sda_s <= {sda_s[0], SDA_IN};
    end
  end

  // state and registered bus outputs
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
      step  <= 2'd0;
      slot  <= 5'd0;
      div   <= 10'd0;
      sh    <= 24'd0;
      scl   <= 1'b1;
      oe    <= 1'b0;
      end_q <= 1'b1;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      step  <= step_n;
      slot  <= slot_n;
      div   <= div_n;
      sh    <= sh_n;
      scl   <= scl_n;
      oe    <= oe_n;
      end_q <= end_n;
      err   <= err_n;
    end
  end

  // sequencing: every step lasts exactly one tick
  always_comb begin
    state_n = state;
    step_n  = step;
    slot_n  = slot;
    div_n   = 10'd0;
    sh_n    = sh;
    scl_n   = scl;
    oe_n    = oe;
    end_n   = end_q;
    err_n   = err;
    if (state == START || state == BIT
        || state == STOP) begin
      div_n = tick ? 10'd0 : div + 10'd1;
    end
    unique case (state)
      IDLE: begin
        if (go_rise) begin
          state_n = START;
          step_n  = 2'd0;
          slot_n  = 5'd0;
          sh_n    = DATA;
          err_n   = 1'b0;
          end_n   = 1'b0;
          scl_n   = 1'b1;
          oe_n    = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          scl_n = 1'b0;
          if (step == 2'd0) begin
            step_n = 2'd1;
          end else begin
            state_n = BIT;
            step_n  = 2'd0;
            oe_n    = ack_now ? 1'b0 : ~sh[23];
          end
        end
      end
      BIT: begin
        if (tick) begin
          unique case (step)
            2'd0: begin
              step_n = 2'd1;
              scl_n  = 1'b1;
            end
            2'd1: begin
              step_n = 2'd2;
            end
            2'd2: begin
              step_n = 2'd3;
              scl_n  = 1'b0;
              if (ack_now && sda_s[1]) begin
                err_n = 1'b1;
              end
            end
            2'd3: begin
              step_n = 2'd0;
              if (!ack_now) begin
                sh_n = {sh[22:0], 1'b0};
              end
              if (slot == 5'd26) begin
                state_n = STOP;
                oe_n    = 1'b1;
              end else begin
                slot_n = slot + 5'd1;
                oe_n   = ack_next ? 1'b0 : ~sh_n[23];
              end
            end
          endcase
        end
      end
      STOP: begin
        if (tick) begin
          unique case (step)
            2'd0: begin
              step_n = 2'd1;
              scl_n  = 1'b1;
            end
            2'd1: begin
              step_n = 2'd2;
              oe_n   = 1'b0;
            end
            default: begin
              state_n = DONE;
              step_n  = 2'd0;
              end_n   = 1'b1;
            end
          endcase
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_codec_writer.sv
// tb_i2c_codec_writer: bus-level model checks of i2c_codec_writer
// at CLK_DIV 4, 2 and 128.
module tb_i2c_codec_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [23:0] data;
  logic [2:0]  go_v;
  logic [2:0]  scl_w;
  logic [2:0]  oe_w;
  logic [2:0]  sda_in_w;
  logic [2:0]  end_w;
  logic [2:0]  err_w;
  int          sel;
  logic [2:0]  ack_mask;
  logic        slave_low;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic int div_of(input int s);
    return (s == 0) ? 4 : ((s == 1) ? 2 : 128);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 4 : ((g == 1) ? 2 : 128);
    assign sda_in_w[g] = ~oe_w[g] & ~(slave_low && sel == g);
    i2c_codec_writer #(.CLK_DIV(D)) u_dut (
      .CLOCK   (clk),
      .RESET   (rst_n),
      .DATA    (data),
      .GO      (go_v[g]),
      .I2C_SCLK(scl_w[g]),
      .SDA_OE  (oe_w[g]),
      .SDA_IN  (sda_in_w[g]),
      .END     (end_w[g]),
      .ACK_ERR (err_w[g])
    );
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // bus monitor on the selected instance
  int          n_start = 0;
  int          n_stop = 0;
  int          n_illegal = 0;
  int          hi_bad = 0;
  int          nbits = 0;
  int          hi_t = 0;
  int          t_fall = 0;
  int          t_rise = 0;
  bit          in_frame = 1'b0;
  logic [23:0] word = 24'd0;
  logic [23:0] last_word = 24'd0;
  logic        prev_scl = 1'b1;
  logic        prev_sda = 1'b1;
  logic        prev_end = 1'b1;

  always @(negedge clk) begin
    logic s_scl, s_sda, s_end;
    s_scl = scl_w[sel];
    s_sda = ~oe_w[sel];
    s_end = end_w[sel];
    if (!rst_n) begin
      in_frame  = 1'b0;
      slave_low = 1'b0;
    end else begin
      if (prev_scl && s_scl && s_sda != prev_sda) begin
        if (!s_sda && !in_frame) begin
          in_frame = 1'b1;
          nbits = 0;
          word = 24'd0;
          n_start++;
        end else if (s_sda && in_frame && nbits == 28) begin
          in_frame = 1'b0;
          n_stop++;
          last_word = word;
        end else begin
          n_illegal++;
        end
      end
      if (!prev_scl && s_scl && in_frame) begin
        nbits++;
        hi_t = cyc;
        if (nbits <= 27 && nbits % 9 != 0)
          word = {word[22:0], s_sda};
        else if (nbits <= 27)
          slave_low = ack_mask[nbits / 9 - 1];
      end
      if (prev_scl && !s_scl && in_frame && nbits > 0) begin
        if (cyc - hi_t != 2 * div_of(sel)) hi_bad++;
        slave_low = 1'b0;
      end
      if (prev_end && !s_end) t_fall = cyc;
      if (!prev_end && s_end) t_rise = cyc;
    end
    prev_scl = s_scl;
    prev_sda = s_sda;
    prev_end = s_end;
  end

  task automatic run_txn(input int s, input logic [23:0] d,
                         input logic [2:0] am, input string tag);
    int st0, sp0, il0, hb0, lat, n, dv;
    dv = div_of(s);
    @(posedge clk); #1;
    sel = s;
    data = d;
    ack_mask = am;
    st0 = n_start;
    sp0 = n_stop;
    il0 = n_illegal;
    hb0 = hi_bad;
    go_v[s] = 1'b1;
    lat = 0;
    while (end_w[s] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " go_to_end"}, 32'(lat <= 3 && !end_w[s]), 1);
    data = 24'($urandom);
    n = 0;
    while (!end_w[s] && n < 113 * dv + 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " end_rise"}, 32'(end_w[s]), 1);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, " starts"}, n_start - st0, 1);
    chk({tag, " stops"}, n_stop - sp0, 1);
    chk({tag, " word"}, 32'(last_word), 32'(d));
    chk({tag, " sda_in_scl_hi"}, n_illegal - il0, 0);
    chk({tag, " scl_hi_time"}, hi_bad - hb0, 0);
    chk({tag, " length"}, t_rise - t_fall, 113 * dv);
    chk({tag, " ack_err"}, 32'(err_w[s]), 32'(am != 3'b111));
    go_v[s] = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  int st0;
  int n;

  initial begin
    rst_n = 1'b0;
    go_v = 3'b000;
    data = 24'd0;
    ack_mask = 3'b111;
    sel = 0;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst scl", 32'(scl_w[i]), 1);
      chk("rst oe", 32'(oe_w[i]), 0);
      chk("rst end", 32'(end_w[i]), 1);
      chk("rst err", 32'(err_w[i]), 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      repeat (25) @(posedge clk);
      #1;
      chk("idle lines",
          32'({scl_w[0], oe_w[0], end_w[0], err_w[0]}), 32'hA);
    end

    run_txn(0, 24'h340C00, 3'b111, "write");
    run_txn(0, 24'h341201, 3'b011, "nack3");
    run_txn(0, 24'h340C00, 3'b111, "clear");

    // GO pulses while busy, then held high after completion
    @(posedge clk); #1;
    sel = 0;
    ack_mask = 3'b111;
    data = 24'h34ABCD;
    st0 = n_start;
    go_v[0] = 1'b1;
    n = 0;
    while (end_w[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abuse busy", 32'(end_w[0]), 0);
    repeat (40) @(posedge clk);
    go_v[0] = 1'b0;
    repeat (6) @(posedge clk);
    go_v[0] = 1'b1;
    repeat (6) @(posedge clk);
    go_v[0] = 1'b0;
    repeat (6) @(posedge clk);
    go_v[0] = 1'b1;
    n = 0;
    while (!end_w[0] && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (200) @(posedge clk);
    #1;
    chk("abuse starts", n_start - st0, 1);
    chk("abuse word", 32'(last_word), 32'h34ABCD);
    chk("abuse idle", 32'({scl_w[0], oe_w[0], end_w[0]}), 32'h5);
    go_v[0] = 1'b0;
    repeat (6) @(posedge clk);
    run_txn(0, 24'h340617, 3'b111, "second");

    // reset during byte 2, after a NACK set ACK_ERR
    @(posedge clk); #1;
    sel = 0;
    ack_mask = 3'b110;
    data = 24'h345678;
    go_v[0] = 1'b1;
    n = 0;
    while (nbits != 14 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_mid reach", nbits, 14);
    chk("rst_mid err_pre", 32'(err_w[0]), 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid lines",
        32'({scl_w[0], oe_w[0], end_w[0], err_w[0]}), 32'hA);
    go_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    run_txn(0, 24'h341201, 3'b111, "post_rst");

    run_txn(1, 24'h341201, 3'b111, "div2");
    run_txn(2, 24'h341201, 3'b111, "div128");

    for (int r = 0; r < 4; r++) begin
      run_txn(0, 24'($urandom), 3'($urandom_range(0, 7)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
